// File: rtl/conv2d_pkg.sv
// Shared types and width helpers for the 2-D convolution window sequencer.
package conv2d_pkg;

    // Frame-level sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Bits needed for a row index 0..h-1 (at least one bit).
    function automatic int row_width(input int h);
        return (h > 1) ? $clog2(h) : 1;
    endfunction

    // Bits needed for a column index 0..w-1 (at least one bit).
    function automatic int col_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/conv2d_window_sequencer_if.sv
// Pixel-in / window-out handshake bundle of the window sequencer.
// The slave modport is the sequencer's view; master is the surrounding datapath.
interface conv2d_window_sequencer_if #(
    parameter int bitWidth    = 8,
    parameter int inputWidth  = 8,
    parameter int inputHeight = 8
) ();
    localparam int ROW_W = conv2d_pkg::row_width(inputHeight);
    localparam int COL_W = conv2d_pkg::col_width(inputWidth);

    logic                       start;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [bitWidth-1:0] in_data;
    logic                       shift_en;
    logic signed [bitWidth-1:0] pix_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [ROW_W-1:0]           out_row;
    logic [COL_W-1:0]           out_col;
    logic                       busy;
    logic                       frame_done;

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, shift_en, pix_data, out_valid, out_row, out_col,
               busy, frame_done
    );

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, shift_en, pix_data, out_valid, out_row, out_col,
               busy, frame_done
    );
endinterface

// File: rtl/conv2d_raster_counter.sv
// Raster-order row/column position counter. Advances one pixel per inc,
// wraps the column into the next row, and parks on the final pixel.
module conv2d_raster_counter
    import conv2d_pkg::*;
#(
    parameter int  W     = 8,
    parameter int  H     = 8,
    localparam int ROW_W = row_width(H),
    localparam int COL_W = col_width(W)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(W - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;

    assign last = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign row  = row_q;
    assign col  = col_q;

    // Next position: clear wins, otherwise step once per accepted pixel.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that leaves one unassigned infers a latch.
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (inc && !last) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Position register.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/conv2d_window_sequencer.sv
// Frame controller for the line-buffer / KxK window datapath: gates the pixel
// stream into the line buffers and flags every fully-populated window to the
// MAC stage, stalling input while an issued window is still unconsumed.
module conv2d_window_sequencer
    import conv2d_pkg::*;
#(
    parameter int filtDimension = 3,
    parameter int bitWidth      = 8,
    parameter int inputWidth    = 8,
    parameter int inputHeight   = 8
) (
    input logic                       clock,
    input logic                       reset_n,
    conv2d_window_sequencer_if.slave  bus
);
    localparam int ROW_W = row_width(inputHeight);
    localparam int COL_W = col_width(inputWidth);

    // First row/column at which the window's bottom-right pixel completes a KxK block.
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(filtDimension - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(filtDimension - 1);

    seq_state_t state_q, state_d;

    logic             out_valid_q, out_valid_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic [COL_W-1:0] out_col_q, out_col_d;

    logic             in_ready;
    logic             busy;
    logic             frame_done;
    logic             accept;
    logic             qualify;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             last;

    logic signed [bitWidth-1:0] pix;

    conv2d_raster_counter #(
        .W (inputWidth),
        .H (inputHeight)
    ) u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_q == IDLE),
        .inc     (accept),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    assign accept  = bus.in_valid && in_ready;
    assign qualify = accept && (row >= ROW_FIRST) && (col >= COL_FIRST);

    // Next state and per-state handshake outputs.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        frame_done = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                // A window still waiting on the MAC stage blocks further pixels.
                in_ready = !out_valid_q || bus.out_ready;
                if (in_ready && bus.in_valid && last) state_d = DRAIN;
            end
            DRAIN: begin
                if (!out_valid_q || bus.out_ready) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Window output: retire on handshake, then a qualifying accept loads the next one.
    always_comb begin
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if (qualify) begin
            out_valid_d = 1'b1;
            out_row_d   = row - ROW_FIRST;
            out_col_d   = col - COL_FIRST;
        end
    end

    // Window output register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    assign pix            = bus.in_data;
    assign bus.pix_data   = pix;
    assign bus.shift_en   = accept;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_row    = out_row_q;
    assign bus.out_col    = out_col_q;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_conv2d_window_sequencer.sv
// Self-checking bench for conv2d_window_sequencer: a cycle model derived from
// pixel counts (n / W, n % W) predicts handshakes, and the list of consumed
// windows is compared against the ideal raster list of window origins.
module tb_conv2d_window_sequencer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sel;
    logic              start;
    logic              in_valid;
    logic              out_ready;
    logic signed [7:0] in_data;

    int vectors    = 0;
    int miscompares = 0;

    // Model state.
    int K, W, H;
    int n;
    int pr, pc;
    bit m_active, m_fd, m_pend;
    int obs_q[$];

    always #5 clk = ~clk;

    conv2d_window_sequencer_if #(.bitWidth(8), .inputWidth(8), .inputHeight(8)) bus_a ();
    conv2d_window_sequencer_if #(.bitWidth(8), .inputWidth(5), .inputHeight(4)) bus_b ();

    assign bus_a.start     = start & ~sel;
    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.out_ready = out_ready;
    assign bus_b.start     = start & sel;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.out_ready = out_ready;

    conv2d_window_sequencer #(
        .filtDimension (3), .bitWidth (8), .inputWidth (8), .inputHeight (8)
    ) dut_a (
        .clock (clk), .reset_n (rst_n), .bus (bus_a.slave)
    );

    conv2d_window_sequencer #(
        .filtDimension (3), .bitWidth (8), .inputWidth (5), .inputHeight (4)
    ) dut_b (
        .clock (clk), .reset_n (rst_n), .bus (bus_b.slave)
    );

    // Observed outputs of whichever DUT is under test, widened to 32 bits.
    logic [31:0] o_in_ready, o_shift_en, o_pix, o_out_valid, o_row, o_col, o_busy, o_fd;
    always_comb begin
        if (sel) begin
            o_in_ready  = 32'(bus_b.in_ready);
            o_shift_en  = 32'(bus_b.shift_en);
            o_pix       = {24'b0, bus_b.pix_data};
            o_out_valid = 32'(bus_b.out_valid);
            o_row       = 32'(bus_b.out_row);
            o_col       = 32'(bus_b.out_col);
            o_busy      = 32'(bus_b.busy);
            o_fd        = 32'(bus_b.frame_done);
        end else begin
            o_in_ready  = 32'(bus_a.in_ready);
            o_shift_en  = 32'(bus_a.shift_en);
            o_pix       = {24'b0, bus_a.pix_data};
            o_out_valid = 32'(bus_a.out_valid);
            o_row       = 32'(bus_a.out_row);
            o_col       = 32'(bus_a.out_col);
            o_busy      = 32'(bus_a.busy);
            o_fd        = 32'(bus_a.frame_done);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string ctx);
        check({ctx, "_in_ready"},   o_in_ready,  32'd0);
        check({ctx, "_shift_en"},   o_shift_en,  32'd0);
        check({ctx, "_out_valid"},  o_out_valid, 32'd0);
        check({ctx, "_out_row"},    o_row,       32'd0);
        check({ctx, "_out_col"},    o_col,       32'd0);
        check({ctx, "_busy"},       o_busy,      32'd0);
        check({ctx, "_frame_done"}, o_fd,        32'd0);
    endtask

    task automatic model_reset();
        n        = 0;
        m_active = 1'b0;
        m_fd     = 1'b0;
        m_pend   = 1'b0;
        pr       = 0;
        pc       = 0;
    endtask

    // One clock: called just after a falling edge with inputs already driven.
    task automatic cycle();
        bit acc, hs, was_active, old_pend, exp_ready;
        int r, c;
        #1;
        exp_ready = m_active && !m_fd && (n < W * H) && (!m_pend || out_ready);
        check("in_ready",   o_in_ready,  32'(exp_ready));
        check("shift_en",   o_shift_en,  32'(in_valid && exp_ready));
        check("pix_data",   o_pix,       {24'b0, in_data});
        check("out_valid",  o_out_valid, 32'(m_pend));
        check("busy",       o_busy,      32'(m_active));
        check("frame_done", o_fd,        32'(m_fd));
        if (m_pend) begin
            check("out_row", o_row, 32'(pr));
            check("out_col", o_col, 32'(pc));
        end
        if (o_out_valid === 32'd1 && out_ready) obs_q.push_back(int'(o_row) * 256 + int'(o_col));
        acc        = in_valid && exp_ready;
        hs         = m_pend && out_ready;
        was_active = m_active;
        old_pend   = m_pend;
        @(posedge clk);
        if (was_active && m_fd) begin
            m_active = 1'b0;
            m_fd     = 1'b0;
        end else if (was_active && n == W * H && (!old_pend || out_ready)) begin
            m_fd = 1'b1;
        end
        if (hs) m_pend = 1'b0;
        if (acc) begin
            r = n / W;
            c = n % W;
            n++;
            if (r >= K - 1 && c >= K - 1) begin
                m_pend = 1'b1;
                pr     = r - K + 1;
                pc     = c - K + 1;
            end
        end
        if (!was_active && start) begin
            m_active = 1'b1;
            n        = 0;
        end
        @(negedge clk);
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random.
    // rmode: 0 always ready, 1 stall 5 cycles at window (2,3), 2 random.
    task automatic run_frame(input int vmode, input int rmode, input bit poke_start, input int abort_at);
        int t, stall, idx, nwin;
        bit aborted;
        t       = 0;
        stall   = 0;
        aborted = 1'b0;
        obs_q.delete();
        start     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = 8'($urandom);
        cycle();
        start = 1'b0;
        while (m_active && t < 3000) begin
            if (abort_at >= 0 && n == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero("abort");
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
                aborted = 1'b1;
                break;
            end
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (t % 2 == 0);
                default: in_valid = ($urandom % 4 != 0);
            endcase
            case (rmode)
                0: out_ready = 1'b1;
                1: begin
                    if (m_pend && pr == 2 && pc == 3 && stall < 5) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = ($urandom % 3 != 0);
            endcase
            start   = poke_start && (t == 10);
            in_data = 8'($urandom);
            cycle();
            t++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("frame_timeout", 32'(m_active), 32'd0);
        if (!aborted) begin
            nwin = (H - K + 1) * (W - K + 1);
            check("window_count", 32'(obs_q.size()), 32'(nwin));
            idx = 0;
            for (int r = 0; r <= H - K; r++) begin
                for (int c = 0; c <= W - K; c++) begin
                    if (idx < obs_q.size()) check("window_seq", 32'(obs_q[idx]), 32'(r * 256 + c));
                    idx++;
                end
            end
            if (rmode == 1) check("stall_cycles", 32'(stall), 32'd5);
        end
        // Settle one idle cycle so the model and DUT both sit in IDLE.
        cycle();
    endtask

    initial begin
        rst_n     = 1'b0;
        sel       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = 8'sd0;
        K = 3; W = 8; H = 8;
        model_reset();

        #12 check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Pixels offered in IDLE are refused and do not move the counters.
        in_valid = 1'b1;
        repeat (3) begin
            in_data = 8'($urandom);
            cycle();
        end
        in_valid = 1'b0;

        run_frame(0, 0, 1'b0, -1);  // gap-free frame
        run_frame(0, 1, 1'b0, -1);  // output stall at window (2,3)
        run_frame(1, 0, 1'b0, -1);  // 1010 input bubbles
        run_frame(0, 0, 1'b0, 30);  // reset mid-frame at pixel 30
        run_frame(0, 0, 1'b0, -1);  // clean frame after abort
        run_frame(2, 2, 1'b1, -1);  // random traffic, start poked while running

        // Narrow image: K=3, W=5, H=4 gives six windows.
        sel = 1'b1;
        K = 3; W = 5; H = 4;
        model_reset();
        cycle();
        run_frame(0, 0, 1'b0, -1);
        run_frame(2, 2, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
